// File: rtl/sdram_port_arbiter.sv
// Multi-client arbiter in front of a single SDRAM controller port.
// One owner at a time, round-robin or fixed priority, with an optional ack timeout.
module sdram_port_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int SEL_WIDTH      = 2,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            sdram_clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            p_acc_i,
    input  logic [NUM_PORTS-1:0]            p_we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_dat_i,
    input  logic [NUM_PORTS*SEL_WIDTH-1:0]  p_sel_i,
    output logic [NUM_PORTS-1:0]            p_ack_o,
    output logic [NUM_PORTS-1:0]            p_err_o,
    output logic [DATA_WIDTH-1:0]           p_dat_o,
    output logic [NUM_PORTS-1:0]            p_grant_o,
    input  logic                            c_idle_i,
    output logic                            c_acc_o,
    output logic                            c_we_o,
    output logic [ADDR_WIDTH-1:0]           c_adr_o,
    output logic [DATA_WIDTH-1:0]           c_dat_o,
    output logic [SEL_WIDTH-1:0]            c_sel_o,
    input  logic                            c_ack_i,
    input  logic [DATA_WIDTH-1:0]           c_dat_i,
    output logic                            busy_o
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             winner_found;
    logic             arb_enable;
    logic [TO_W-1:0]  timeout_cnt;
    int               cand;

    // Round-robin search begins just after the previous owner; fixed mode scans from port 0.
    always_comb begin
        winner_idx   = '0;
        winner_found = 1'b0;
        cand         = 0;
        cand_idx     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (RR_MODE != 0)
                cand = (int'(last_grant) + 1 + i) % NUM_PORTS;
            else
                cand = i;
            cand_idx = IDX_W'(cand);
            if (!winner_found && p_acc_i[cand_idx]) begin
                winner_found = 1'b1;
                winner_idx   = cand_idx;
            end
        end
    end

    // arb_enable holds off arbitration for the first cycle after reset is released.
    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            c_acc_o     <= 1'b0;
            c_we_o      <= 1'b0;
            c_adr_o     <= '0;
            c_dat_o     <= '0;
            c_sel_o     <= '0;
            p_ack_o     <= '0;
            p_err_o     <= '0;
            p_grant_o   <= '0;
            p_dat_o     <= '0;
            grant_idx   <= '0;
            last_grant  <= LAST_PORT;
            arb_enable  <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            arb_enable <= 1'b1;
            p_ack_o    <= '0;
            p_err_o    <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_enable && c_idle_i && winner_found) begin
                        grant_idx   <= winner_idx;
                        last_grant  <= winner_idx;
                        p_grant_o   <= NUM_PORTS'(1) << winner_idx;
                        c_acc_o     <= 1'b1;
                        c_we_o      <= p_we_i[winner_idx];
                        c_adr_o     <= p_adr_i[winner_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        c_dat_o     <= p_dat_i[winner_idx*DATA_WIDTH +: DATA_WIDTH];
                        c_sel_o     <= p_sel_i[winner_idx*SEL_WIDTH +: SEL_WIDTH];
                        timeout_cnt <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A late ack takes precedence over a timeout landing in the same cycle.
                    if (c_ack_i) begin
                        c_acc_o            <= 1'b0;
                        c_we_o             <= 1'b0;
                        p_ack_o[grant_idx] <= 1'b1;
                        if (!c_we_o)
                            p_dat_o <= c_dat_i;
                        state <= ST_RELEASE;
                    end else if (TIMEOUT_CYCLES > 0 && timeout_cnt == TO_LAST) begin
                        c_acc_o            <= 1'b0;
                        c_we_o             <= 1'b0;
                        p_err_o[grant_idx] <= 1'b1;
                        timeout_cnt        <= TO_MAX;
                        state              <= ST_RELEASE;
                    end else if (TIMEOUT_CYCLES > 0 && timeout_cnt != TO_MAX) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Wait for the owner to drop its request so a stale one is not re-granted.
                    if (!p_acc_i[grant_idx]) begin
                        p_grant_o <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a round-robin/timeout instance and a fixed-priority instance
// share the client buses; a small controller model acks a configurable number of cycles after c_acc_o.
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int SW = 2;

    logic sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    logic               reset;
    logic [NP-1:0]      p_we;
    logic [NP*AW-1:0]   p_adr;
    logic [NP*DW-1:0]   p_dat;
    logic [NP*SW-1:0]   p_sel;
    logic               c_idle;

    logic [NP-1:0]      p_acc   [2];
    logic               c_ack   [2];
    logic [DW-1:0]      c_dat_in[2];
    logic [NP-1:0]      p_ack   [2];
    logic [NP-1:0]      p_err   [2];
    logic [NP-1:0]      p_grant [2];
    logic [DW-1:0]      p_dat_o [2];
    logic [DW-1:0]      c_dat_o [2];
    logic               c_acc   [2];
    logic               c_we    [2];
    logic               busy    [2];
    logic [AW-1:0]      c_adr   [2];
    logic [SW-1:0]      c_sel   [2];

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
                         .RR_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .sdram_clk(sdram_clk), .reset(reset),
        .p_acc_i(p_acc[0]), .p_we_i(p_we), .p_adr_i(p_adr), .p_dat_i(p_dat), .p_sel_i(p_sel),
        .p_ack_o(p_ack[0]), .p_err_o(p_err[0]), .p_dat_o(p_dat_o[0]), .p_grant_o(p_grant[0]),
        .c_idle_i(c_idle), .c_acc_o(c_acc[0]), .c_we_o(c_we[0]), .c_adr_o(c_adr[0]),
        .c_dat_o(c_dat_o[0]), .c_sel_o(c_sel[0]), .c_ack_i(c_ack[0]), .c_dat_i(c_dat_in[0]),
        .busy_o(busy[0])
    );

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
                         .RR_MODE(0), .TIMEOUT_CYCLES(0)) dut_fp (
        .sdram_clk(sdram_clk), .reset(reset),
        .p_acc_i(p_acc[1]), .p_we_i(p_we), .p_adr_i(p_adr), .p_dat_i(p_dat), .p_sel_i(p_sel),
        .p_ack_o(p_ack[1]), .p_err_o(p_err[1]), .p_dat_o(p_dat_o[1]), .p_grant_o(p_grant[1]),
        .c_idle_i(c_idle), .c_acc_o(c_acc[1]), .c_we_o(c_we[1]), .c_adr_o(c_adr[1]),
        .c_dat_o(c_dat_o[1]), .c_sel_o(c_sel[1]), .c_ack_i(c_ack[1]), .c_dat_i(c_dat_in[1]),
        .busy_o(busy[1])
    );

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            lat;
    } txn_t;

    typedef struct {
        logic [NP-1:0] ack;
        logic [NP-1:0] err;
        logic [DW-1:0] rdat;
        int            lat;
    } resp_t;

    txn_t          exp_txn[$];
    resp_t         exp_resp[$];
    int            exp_fp[$];
    txn_t          cur;

    int            checks = 0;
    int            passed = 0;
    int            cyc = 0;
    int            ref_cyc = 0;
    int            grant_cyc = 0;
    int            ctrl_delay = 3;
    int            ctrl_cnt[2];
    logic [DW-1:0] ctrl_rdata = '0;
    logic [DW-1:0] last_rdat = '0;
    logic [NP-1:0] want[2];
    logic          auto_clear = 1'b1;
    logic          prev_acc[2];

    logic          cfg_we [NP];
    logic [AW-1:0] cfg_adr[NP];
    logic [DW-1:0] cfg_dat[NP];
    logic [SW-1:0] cfg_sel[NP];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic driveClients();
        for (int d = 0; d < 2; d++)
            p_acc[d] = want[d] & ~(p_ack[d] | p_err[d]);
    endtask

    task automatic setPort(input int port, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        cfg_we[port]  = we;
        cfg_adr[port] = adr;
        cfg_dat[port] = dat;
        cfg_sel[port] = sel;
        p_we[port]            = we;
        p_adr[port*AW +: AW]  = adr;
        p_dat[port*DW +: DW]  = dat;
        p_sel[port*SW +: SW]  = sel;
    endtask

    // outcome: 0 = no response expected, 1 = ack, 2 = timeout error.
    task automatic expectTxn(input int port, input int glat, input int outcome, input int rlat);
        txn_t  t;
        resp_t r;
        t.port = port;
        t.we   = cfg_we[port];
        t.adr  = cfg_adr[port];
        t.dat  = cfg_dat[port];
        t.sel  = cfg_sel[port];
        t.lat  = glat;
        exp_txn.push_back(t);
        if (outcome != 0) begin
            r.ack = (outcome == 1) ? (NP'(1) << port) : '0;
            r.err = (outcome == 2) ? (NP'(1) << port) : '0;
            if (outcome == 1 && !cfg_we[port])
                last_rdat = ctrl_rdata;
            r.rdat = last_rdat;
            r.lat  = rlat;
            exp_resp.push_back(r);
        end
    endtask

    task automatic applyStimulus(input int port, input int glat, input int outcome, input int rlat);
        want[0][port] = 1'b1;
        ref_cyc = cyc;
        expectTxn(port, glat, outcome, rlat);
        driveClients();
    endtask

    // One clock: observe outputs at the falling edge, then update controller and client models.
    task automatic tick();
        resp_t r;
        int    e;
        @(negedge sdram_clk);
        cyc++;
        if (c_acc[0] && !prev_acc[0]) begin
            if (exp_txn.size() == 0) begin
                checkOutput("unexpected_grant", 64'(p_grant[0]), 64'd0);
            end else begin
                cur = exp_txn.pop_front();
                grant_cyc = cyc;
                checkOutput("grant", 64'(p_grant[0]), 64'(NP'(1) << cur.port));
                checkOutput("c_we", 64'(c_we[0]), 64'(cur.we));
                checkOutput("c_adr", 64'(c_adr[0]), 64'(cur.adr));
                checkOutput("c_dat", 64'(c_dat_o[0]), 64'(cur.dat));
                checkOutput("c_sel", 64'(c_sel[0]), 64'(cur.sel));
                checkOutput("busy", 64'(busy[0]), 64'd1);
                if (cur.lat >= 0)
                    checkOutput("grant_latency", 64'(cyc - ref_cyc), 64'(cur.lat));
            end
        end else if (c_acc[0]) begin
            checkOutput("hold_adr", 64'(c_adr[0]), 64'(cur.adr));
            checkOutput("hold_dat", 64'(c_dat_o[0]), 64'(cur.dat));
            checkOutput("hold_we", 64'(c_we[0]), 64'(cur.we));
        end
        if ((p_ack[0] | p_err[0]) != '0) begin
            if (exp_resp.size() == 0) begin
                checkOutput("spurious_resp", 64'({p_err[0], p_ack[0]}), 64'd0);
            end else begin
                r = exp_resp.pop_front();
                checkOutput("p_ack", 64'(p_ack[0]), 64'(r.ack));
                checkOutput("p_err", 64'(p_err[0]), 64'(r.err));
                checkOutput("p_dat", 64'(p_dat_o[0]), 64'(r.rdat));
                checkOutput("resp_latency", 64'(cyc - grant_cyc), 64'(r.lat));
                checkOutput("c_acc_dropped", 64'(c_acc[0]), 64'd0);
            end
        end
        if (c_acc[1] && !prev_acc[1]) begin
            if (exp_fp.size() == 0) begin
                checkOutput("fp_unexpected_grant", 64'(p_grant[1]), 64'd0);
            end else begin
                e = exp_fp.pop_front();
                checkOutput("fp_grant", 64'(p_grant[1]), 64'(NP'(1) << e));
            end
        end
        for (int d = 0; d < 2; d++) begin
            prev_acc[d] = c_acc[d];
            if (c_acc[d] && !c_ack[d]) begin
                ctrl_cnt[d]++;
                if (ctrl_delay != 0 && ctrl_cnt[d] >= ctrl_delay)
                    c_ack[d] = 1'b1;
            end else begin
                c_ack[d]    = 1'b0;
                ctrl_cnt[d] = 0;
            end
            c_dat_in[d] = c_ack[d] ? ctrl_rdata : 16'h0BAD;
            if (auto_clear)
                want[d] = want[d] & ~(p_ack[d] | p_err[d]);
        end
        driveClients();
    endtask

    task automatic waitGrant(input string tag, input int budget);
        for (int i = 0; i < budget && exp_txn.size() != 0; i++)
            tick();
        if (exp_txn.size() != 0)
            checkOutput({"wait_grant_", tag}, 64'(exp_txn.size()), 64'd0);
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int i = 0; i < budget && (exp_txn.size() != 0 || exp_resp.size() != 0 || busy[0]); i++)
            tick();
        if (exp_txn.size() != 0 || exp_resp.size() != 0 || busy[0])
            checkOutput({"wait_done_", tag}, 64'(exp_txn.size() + exp_resp.size()), 64'd0);
    endtask

    task automatic checkResetState(input int d);
        checkOutput("rst_p_ack", 64'(p_ack[d]), 64'd0);
        checkOutput("rst_p_err", 64'(p_err[d]), 64'd0);
        checkOutput("rst_p_grant", 64'(p_grant[d]), 64'd0);
        checkOutput("rst_p_dat", 64'(p_dat_o[d]), 64'd0);
        checkOutput("rst_c_acc", 64'(c_acc[d]), 64'd0);
        checkOutput("rst_c_we", 64'(c_we[d]), 64'd0);
        checkOutput("rst_c_adr", 64'(c_adr[d]), 64'd0);
        checkOutput("rst_c_dat", 64'(c_dat_o[d]), 64'd0);
        checkOutput("rst_c_sel", 64'(c_sel[d]), 64'd0);
        checkOutput("rst_busy", 64'(busy[d]), 64'd0);
    endtask

    initial begin
        reset  = 1'b1;
        c_idle = 1'b1;
        p_we   = '0;
        p_adr  = '0;
        p_dat  = '0;
        p_sel  = '0;
        for (int d = 0; d < 2; d++) begin
            want[d]     = '0;
            p_acc[d]    = '0;
            c_ack[d]    = 1'b0;
            c_dat_in[d] = '0;
            ctrl_cnt[d] = 0;
            prev_acc[d] = 1'b0;
        end
        for (int p = 0; p < NP; p++)
            setPort(p, 1'b0, '0, '0, '0);

        repeat (3) tick();
        checkResetState(0);
        checkResetState(1);
        reset = 1'b0;
        repeat (2) tick();

        // Single write on port 0; its bus is scrambled while the transaction is in flight.
        setPort(0, 1'b1, 32'h0000_0010, 16'hF001, 2'b11);
        applyStimulus(0, 1, 1, 3);
        waitGrant("write0", 10);
        p_adr[0 +: AW] = 32'hFFFF_FFFF;
        p_dat[0 +: DW] = 16'h0000;
        p_we[0]        = 1'b0;
        waitDone("write0", 20);

        // Port 0 write whose request is withdrawn during BUSY: still completes.
        setPort(0, 1'b1, 32'h0000_0020, 16'h1357, 2'b01);
        applyStimulus(0, 1, 1, 3);
        waitGrant("drop0", 10);
        want[0][0] = 1'b0;
        driveClients();
        waitDone("drop0", 20);

        // Port 1 read returning 0xABCD.
        ctrl_rdata = 16'hABCD;
        setPort(1, 1'b0, 32'h0000_0200, 16'h0000, 2'b11);
        applyStimulus(1, 1, 1, 3);
        waitDone("read1", 20);

        // Controller busy: nothing may be granted until c_idle_i rises.
        c_idle = 1'b0;
        ctrl_rdata = 16'h1234;
        setPort(0, 1'b0, 32'h0000_0300, 16'h0000, 2'b11);
        setPort(1, 1'b1, 32'h0000_0400, 16'h4321, 2'b10);
        want[0] = 2'b11;
        driveClients();
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_c_acc", 64'(c_acc[0]), 64'd0);
            checkOutput("idle_grant", 64'(p_grant[0]), 64'd0);
        end
        c_idle  = 1'b1;
        ref_cyc = cyc;
        expectTxn(0, 1, 1, 3);
        expectTxn(1, -1, 1, 3);
        waitDone("ctrl_idle", 40);

        // Both ports keep requesting: round-robin alternates, fixed priority stays on port 0.
        auto_clear = 1'b0;
        ctrl_rdata = 16'h0FA5;
        setPort(0, 1'b0, 32'h0000_0100, 16'h0000, 2'b11);
        setPort(1, 1'b0, 32'h0000_0200, 16'h0000, 2'b01);
        expectTxn(0, 1, 1, 3);
        expectTxn(1, -1, 1, 3);
        expectTxn(0, -1, 1, 3);
        expectTxn(1, -1, 1, 3);
        for (int i = 0; i < 3; i++)
            exp_fp.push_back(0);
        ref_cyc = cyc;
        want[0] = 2'b11;
        want[1] = 2'b11;
        driveClients();
        for (int i = 0; i < 200 && (exp_txn.size() != 0 || exp_fp.size() != 0); i++) begin
            tick();
            if (exp_txn.size() == 0)
                want[0] = '0;
            if (exp_fp.size() == 0)
                want[1] = '0;
            driveClients();
        end
        checkOutput("rr_fp_grants_seen", 64'(exp_txn.size() + exp_fp.size()), 64'd0);
        want[0] = '0;
        want[1] = '0;
        driveClients();
        waitDone("rr", 40);
        repeat (3) tick();
        auto_clear = 1'b1;

        // No ack at all: error pulse exactly 8 cycles after the grant.
        ctrl_delay = 0;
        setPort(1, 1'b1, 32'h3000_0040, 16'h7777, 2'b10);
        applyStimulus(1, 1, 2, 8);
        waitDone("timeout", 40);

        // Ack arriving on the very cycle the limit is reached wins over the timeout.
        ctrl_delay = 8;
        ctrl_rdata = 16'h5EED;
        setPort(0, 1'b0, 32'h0000_0500, 16'h0000, 2'b11);
        applyStimulus(0, 1, 1, 8);
        waitDone("ack_at_limit", 40);

        // Reset in the middle of a port 0 transaction; afterwards port 0 wins first again.
        ctrl_delay = 0;
        setPort(0, 1'b1, 32'h0000_0044, 16'hC0DE, 2'b11);
        applyStimulus(0, 1, 0, 0);
        waitGrant("pre_reset", 10);
        tick();
        setPort(1, 1'b0, 32'h0000_0088, 16'h0000, 2'b01);
        want[0] = 2'b11;
        driveClients();
        reset = 1'b1;
        tick();
        checkResetState(0);
        last_rdat  = '0;
        reset      = 1'b0;
        ctrl_delay = 3;
        ctrl_rdata = 16'h9999;
        ref_cyc    = cyc;
        expectTxn(0, 2, 1, 3);
        expectTxn(1, -1, 1, 3);
        waitDone("post_reset", 40);
        repeat (4) tick();

        checkOutput("txn_queue_empty", 64'(exp_txn.size()), 64'd0);
        checkOutput("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
        checkOutput("fp_queue_empty", 64'(exp_fp.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameters:
- NUM_PORTS, 2, number of client ports (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 16, data width.
- SEL_WIDTH, 2, byte-select width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (port 0 highest).
- TIMEOUT_CYCLES, 0, cycles to wait for c_ack_i before abort (0 = disabled).

REQ-002 SHALL have ports (name, direction, width, meaning):
- sdram_clk, in, 1, clock.
- reset, in, 1, reset.
- p_acc_i, in, NUM_PORTS, per-port access request.
- p_we_i, in, NUM_PORTS, per-port write enable.
- p_adr_i, in, NUM_PORTS*ADDR_WIDTH, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- p_dat_i, in, NUM_PORTS*DATA_WIDTH, per-port write data, packed the same way.
- p_sel_i, in, NUM_PORTS*SEL_WIDTH, per-port byte selects, packed the same way.
- p_ack_o, out, NUM_PORTS, one-cycle completion pulse per port.
- p_err_o, out, NUM_PORTS, one-cycle timeout pulse per port.
- p_dat_o, out, DATA_WIDTH, read data, shared by all ports.
- p_grant_o, out, NUM_PORTS, one-hot owner of the current transaction.
- c_idle_i, in, 1, controller idle.
- c_acc_o, out, 1, controller access request.
- c_we_o, out, 1, controller write enable.
- c_adr_o, out, ADDR_WIDTH, controller address.
- c_dat_o, out, DATA_WIDTH, controller write data.
- c_sel_o, out, SEL_WIDTH, controller byte selects.
- c_ack_i, in, 1, controller completion.
- c_dat_i, in, DATA_WIDTH, controller read data, valid with c_ack_i.
- busy_o, out, 1, high in every state except IDLE.

REQ-003 SHALL use reset (synchronous, active-high) and clock sdram_clk; all state changes on the rising edge of sdram_clk.

Function
REQ-004 SHALL implement states IDLE, BUSY, RELEASE.

REQ-005 IDLE: when c_idle_i=1 and any p_acc_i bit is set:
- select the winner per REQ-008;
- register its adr/dat/sel/we into c_*;
- set c_acc_o=1 and the one-hot p_grant_o;
- go to BUSY.

REQ-006 Latency: a request sampled in cycle N with c_idle_i=1 SHALL give c_acc_o=1 in cycle N+1.

REQ-007 IDLE with c_idle_i=0 SHALL grant nothing, whatever p_acc_i is.

REQ-008 Arbitration:
- RR_MODE=1: search starts at (last_grant+1) mod NUM_PORTS and takes the first requester.
- last_grant updates on every grant; the pointer wraps from NUM_PORTS-1 to 0.
- RR_MODE=0: the lowest-index requester wins.

REQ-009 BUSY: c_acc_o, c_we_o, c_adr_o, c_dat_o and c_sel_o SHALL hold constant; changes on the p_* inputs are ignored.

REQ-010 BUSY with c_ack_i=1 in cycle M:
- cycle M+1: c_acc_o=0, c_we_o=0;
- cycle M+1: p_ack_o[granted]=1 for exactly one cycle;
- p_dat_o <= c_dat_i on reads, unchanged on writes;
- go to RELEASE.

REQ-011 Timeout, when TIMEOUT_CYCLES>0:
- a counter runs while in BUSY;
- if it reaches TIMEOUT_CYCLES without c_ack_i, drop c_acc_o;
- pulse p_err_o[granted] for one cycle (no p_ack_o);
- go to RELEASE.
- If c_ack_i arrives in the same cycle the limit is reached, ack wins.

REQ-012 A port that deasserts p_acc_i during BUSY SHALL NOT abort the transaction; its ack/err pulse is still issued.

REQ-013 RELEASE: stay until p_acc_i[granted]=0, then clear p_grant_o and go to IDLE. This prevents re-granting a stale request.

REQ-014 p_ack_o and p_err_o SHALL never have more than one bit set, and never both in the same cycle.

REQ-015 Width rules:
- the grant index is $clog2(NUM_PORTS) bits;
- the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates;
- NUM_PORTS=1 SHALL work with the grant always 0.

Reset
REQ-016 While reset=1:
- state=IDLE;
- c_acc_o, c_we_o, c_adr_o, c_dat_o, c_sel_o = 0;
- p_ack_o, p_err_o, p_grant_o, p_dat_o = 0;
- busy_o=0, timeout counter=0;
- last_grant=NUM_PORTS-1, so port 0 wins first.

REQ-017 Reset asserted mid-transaction SHALL abandon it without any ack/err pulse. No grant occurs in the first cycle after reset deasserts; arbitration resumes in the second.

Verification
REQ-018 Single write: p_acc_i=01, port 0 adr=0x10, dat=0xF001, c_idle_i=1 -> next cycle c_acc_o=1, c_we_o=1, c_adr_o=0x10, c_dat_o=0xF001; c_ack_i pulse -> p_ack_o=01 one cycle later, for one cycle.

REQ-019 Read return: port 1 read, c_dat_i=0xABCD with c_ack_i -> p_dat_o=0xABCD and p_ack_o=10 in the same cycle.

REQ-020 Round-robin: both ports hold p_acc_i continuously, controller acks each access after 3 cycles -> grant order 0,1,0,1; with RR_MODE=0 -> 0,0,0.

REQ-021 Controller not idle: c_idle_i=0 for 10 cycles with p_acc_i=11 -> c_acc_o stays 0; c_idle_i=1 -> port 0 granted the next cycle.

REQ-022 Timeout: TIMEOUT_CYCLES=8, no c_ack_i -> c_acc_o drops and p_err_o pulses on the granted port exactly 8 cycles after c_acc_o rose; p_ack_o stays 0.

REQ-023 Reset mid-BUSY: reset during BUSY -> all outputs 0 the next cycle and no ack/err pulse; the first post-reset grant goes to port 0.
